buffer_skid: RTL and testbench
==============================

BUFFER_SKID -- requirements
Module: buffer_skid

Interface
REQ-001 The module SHALL have parameter DATA_W, default 32, width of each data field (ALU result, DR1, DR2).
REQ-002 The module SHALL have parameter ADDR_W, default 5, width of the register-file write address.
REQ-003 The module SHALL have parameter CTRL_W, default 3, control bits; bit0 = wE_BR, bit1 = W_ram, bit2 = R_ram.
REQ-004 The module SHALL have one clock and an asynchronous active-high reset, listed first: clk  in  1  rising-edge clock; rst  in  1  asynchronous active-high reset.
REQ-005 The module SHALL have ports in_valid  in  1  upstream stage holds a valid instruction; in_ready  out  1  buffer can accept, registered.
REQ-006 The module SHALL have ports in_ctrl  in  CTRL_W; in_dw_alu, in_dr1, in_dr2  in  DATA_W each; in_wa  in  ADDR_W  upstream payload.
REQ-007 The module SHALL have ports out_valid  out  1; out_ready  in  1  downstream accepts; out_ctrl, out_dw_alu, out_dr1, out_dr2, out_wa  out  payload widths matching inputs.
REQ-008 The module SHALL have ports flush  in  1  synchronous pipeline flush (branch/exception); occ  out  2  entries held, 0..2.

Function
REQ-009 The buffer SHALL be a two-entry skid buffer: MAIN slot drives the outputs; SKID slot absorbs one beat when downstream stalls.
REQ-010 The buffer SHALL define an input handshake as in_valid & in_ready and an output handshake as out_valid & out_ready, both sampled at the rising clk edge.
REQ-011 The buffer SHALL have states EMPTY (occ=0), ONE (MAIN valid, occ=1), and FULL (MAIN+SKID valid, occ=2).
REQ-012 In EMPTY, an input handshake SHALL load MAIN and move the state to ONE.
REQ-013 In ONE, simultaneous input and output handshakes SHALL load MAIN with the input payload and keep the state in ONE.
REQ-014 In ONE, an input handshake alone SHALL load SKID and move the state to FULL; an output handshake alone SHALL move the state to EMPTY.
REQ-015 In FULL, an output handshake SHALL move SKID into MAIN and move the state to ONE; no input is accepted in FULL.
REQ-016 in_ready SHALL be a register equal to 1 in EMPTY/ONE and 0 in FULL; it SHALL never depend combinationally on out_ready.
REQ-017 Latency SHALL be 1 cycle from input handshake to out_valid=1 when the buffer is EMPTY.
REQ-018 Throughput SHALL be 1 beat/cycle while out_ready is held at 1.
REQ-019 Payload order SHALL be preserved: no beat dropped, duplicated or reordered except by flush.
REQ-020 out_ctrl SHALL read all-zero whenever out_valid=0 (bubble carries no write-enables); data outputs are don't-care when invalid.
REQ-021 flush=1 SHALL have highest priority: next state EMPTY, both slots invalid, out_ctrl zeroed, occ=0.
REQ-022 An input handshake coincident with flush SHALL be consumed and discarded.
REQ-023 An output handshake coincident with flush SHALL count as delivered downstream, and the beat SHALL not reappear.
REQ-024 Widths SHALL pass through unmodified, with no arithmetic, truncation or extension on any field.

Reset
REQ-025 rst=1 SHALL immediately, independent of clk, force state EMPTY, out_valid=0, in_ready=1, occ=0, and all out_* payloads, SKID contents and out_ctrl to 0.
REQ-026 rst asserted mid-transfer SHALL discard all held beats, and the first post-reset handshake SHALL occur no earlier than the first rising edge after rst deassertion.

Structure
REQ-027 A shared package SHALL hold the DATA_W/ADDR_W/CTRL_W defaults, the control-bit index constants (WE_BR, W_RAM, R_RAM), and the state enumeration (EMPTY, ONE, FULL).
REQ-028 One sub-module, buffer_slot, SHALL be used: a parametrised valid+payload register with load, clear and async reset, instantiated twice (MAIN, SKID).

Verification
REQ-029 Verification SHALL cover: streaming with out_ready=1, 10 beats with in_dw_alu=1..10 -> out_dw_alu 1..10 on consecutive cycles, first one cycle after the first handshake, occ never >1.
REQ-030 Verification SHALL cover: beat A accepted, out_ready=0 for 3 cycles while B is offered -> B captured, in_ready=0, occ=2; on out_ready=1, A then B delivered, in_ready returns to 1.
REQ-031 Verification SHALL cover: FULL with in_ctrl=3'b111, flush pulse -> next cycle out_valid=0, out_ctrl=3'b000, occ=0, and no stale beat later.
REQ-032 Verification SHALL cover: flush coincident with an input handshake of in_wa=5'd17 -> out_wa=17 never presented.
REQ-033 Verification SHALL cover: rst asserted asynchronously between edges while FULL -> outputs zero within the same cycle, in_ready=1 and occ=0 after release.
REQ-034 Verification SHALL cover: random in_valid/out_ready for 10k cycles with DATA_W=64, ADDR_W=6 -> scoreboard order match, out_ctrl=0 whenever out_valid=0.

Source files
------------

// File: rtl/buffer_skid_pkg.sv
// Shared defaults, control-bit positions and occupancy states for the
// execute-to-memory skid buffer.
package buffer_skid_pkg;

  localparam int DATA_W_DEF = 32;
  localparam int ADDR_W_DEF = 5;
  localparam int CTRL_W_DEF = 3;

  localparam int WE_BR = 0;
  localparam int W_RAM = 1;
  localparam int R_RAM = 2;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

endpackage

// File: rtl/buffer_skid_slot.sv
// One valid+payload register. Clear wins over load and zeroes the payload,
// so an empty slot never carries stale control bits.
module buffer_slot #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic         clear,
  input  logic [W-1:0] d,
  output logic         valid,
  output logic [W-1:0] q
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid <= 1'b0;
      q     <= '0;
    end else if (clear) begin
      valid <= 1'b0;
      q     <= '0;
    end else if (load) begin
      valid <= 1'b1;
      q     <= d;
    end else begin
      valid <= valid;
      q     <= q;
    end
  end

endmodule

// File: rtl/buffer_skid.sv
// Two-entry skid buffer between pipeline stages: MAIN drives the outputs,
// SKID catches the one beat accepted while downstream stalls.
module buffer_skid
  import buffer_skid_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int CTRL_W = CTRL_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_dw_alu,
  input  logic [DATA_W-1:0] in_dr1,
  input  logic [DATA_W-1:0] in_dr2,
  input  logic [ADDR_W-1:0] in_wa,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_dw_alu,
  output logic [DATA_W-1:0] out_dr1,
  output logic [DATA_W-1:0] out_dr2,
  output logic [ADDR_W-1:0] out_wa,
  input  logic              flush,
  output logic [1:0]        occ
);

  localparam int PW = CTRL_W + 3 * DATA_W + ADDR_W;

  state_t        state, state_next;
  logic [PW-1:0] in_pay, main_d, main_q, skid_q;
  logic          main_load, main_clear, skid_load, skid_clear, main_from_skid;
  logic          skid_valid, in_hs, out_hs;
  logic [1:0]    occ_next;

  assign in_pay = {in_ctrl, in_dw_alu, in_dr1, in_dr2, in_wa};
  assign in_hs  = in_valid & in_ready;
  assign out_hs = out_valid & out_ready;
  assign main_d = main_from_skid ? skid_q : in_pay;
  assign {out_ctrl, out_dw_alu, out_dr1, out_dr2, out_wa} = main_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= EMPTY;
      in_ready <= 1'b1;
      occ      <= 2'd0;
    end else begin
      state    <= state_next;
      in_ready <= (state_next != FULL);
      occ      <= occ_next;
    end
  end

  // Flush overrides everything; a beat handshaken alongside it is simply lost.
  always_comb begin
    state_next     = state;
    main_load      = 1'b0;
    main_clear     = 1'b0;
    skid_load      = 1'b0;
    skid_clear     = 1'b0;
    main_from_skid = 1'b0;
    if (flush) begin
      state_next = EMPTY;
      main_clear = 1'b1;
      skid_clear = 1'b1;
    end else begin
      case (state)
        EMPTY: begin
          if (in_hs) begin
            main_load  = 1'b1;
            state_next = ONE;
          end else begin
            state_next = EMPTY;
          end
        end
        ONE: begin
          if (in_hs && out_hs) begin
            main_load  = 1'b1;
            state_next = ONE;
          end else if (in_hs) begin
            skid_load  = 1'b1;
            state_next = FULL;
          end else if (out_hs) begin
            main_clear = 1'b1;
            state_next = EMPTY;
          end else begin
            state_next = ONE;
          end
        end
        FULL: begin
          if (out_hs) begin
            main_load      = 1'b1;
            main_from_skid = 1'b1;
            skid_clear     = 1'b1;
            state_next     = ONE;
          end else begin
            state_next = FULL;
          end
        end
        default: begin
          main_clear = 1'b1;
          skid_clear = 1'b1;
          state_next = EMPTY;
        end
      endcase
    end
  end

  always_comb begin
    case (state_next)
      EMPTY:   occ_next = 2'd0;
      ONE:     occ_next = 2'd1;
      FULL:    occ_next = 2'd2;
      default: occ_next = 2'd0;
    endcase
  end

  buffer_slot #(.W(PW)) u_main (
    .clk   (clk),
    .rst   (rst),
    .load  (main_load),
    .clear (main_clear),
    .d     (main_d),
    .valid (out_valid),
    .q     (main_q)
  );

  buffer_slot #(.W(PW)) u_skid (
    .clk   (clk),
    .rst   (rst),
    .load  (skid_load),
    .clear (skid_clear),
    .d     (in_pay),
    .valid (skid_valid),
    .q     (skid_q)
  );

endmodule

// File: tb/tb_buffer_skid.sv
// Scoreboard bench for buffer_skid: a FIFO-of-beats reference (max two held,
// flush/reset empty it) is compared with the DUT every cycle.
module tb_buffer_skid;
  import buffer_skid_pkg::*;

  localparam int DW = 64;
  localparam int AW = 6;
  localparam int CW = 3;

  typedef struct {
    logic [CW-1:0] ctrl;
    logic [DW-1:0] dw;
    logic [DW-1:0] dr1;
    logic [DW-1:0] dr2;
    logic [AW-1:0] wa;
  } beat_t;

  logic clk = 1'b0;
  logic rst, in_valid, in_ready, out_valid, out_ready, flush;
  logic [CW-1:0] in_ctrl, out_ctrl;
  logic [DW-1:0] in_dw_alu, in_dr1, in_dr2, out_dw_alu, out_dr1, out_dr2;
  logic [AW-1:0] in_wa, out_wa;
  logic [1:0] occ;

  beat_t sb[$];
  beat_t b;
  int total_cnt = 0;
  int pass_cnt = 0;
  int seen17 = 0;
  logic watch17 = 1'b0;
  logic acc_in, acc_out;
  logic [CW-1:0] all_ctrl;

  buffer_skid #(.DATA_W(DW), .ADDR_W(AW), .CTRL_W(CW)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_ctrl(in_ctrl), .in_dw_alu(in_dw_alu), .in_dr1(in_dr1), .in_dr2(in_dr2), .in_wa(in_wa),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_ctrl(out_ctrl), .out_dw_alu(out_dw_alu), .out_dr1(out_dr1), .out_dr2(out_dr2), .out_wa(out_wa),
    .flush(flush), .occ(occ)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    total_cnt++;
    if (got === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [CW-1:0] c, input logic [DW-1:0] d, input logic [AW-1:0] a);
    in_valid  = v;
    in_ctrl   = c;
    in_dw_alu = d;
    in_dr1    = ~d;
    in_dr2    = d ^ {DW{1'b1}} ^ 64'h5A5A_0000_0000_A5A5;
    in_wa     = a;
  endtask

  // Mid-cycle monitor: compare DUT with the model, then apply the coming edge.
  always @(negedge clk) begin
    if (rst) sb.delete();
    chk("occ", {62'd0, occ}, sb.size());
    chk("in_ready", {63'd0, in_ready}, {63'd0, sb.size() < 2});
    chk("out_valid", {63'd0, out_valid}, {63'd0, sb.size() > 0});
    if (sb.size() > 0) begin
      chk("out_ctrl", {61'd0, out_ctrl}, {61'd0, sb[0].ctrl});
      chk("out_dw_alu", out_dw_alu, sb[0].dw);
      chk("out_dr1", out_dr1, sb[0].dr1);
      chk("out_dr2", out_dr2, sb[0].dr2);
      chk("out_wa", {58'd0, out_wa}, {58'd0, sb[0].wa});
    end else begin
      chk("bubble_ctrl", {61'd0, out_ctrl}, 64'd0);
    end
    if (watch17 && out_valid && out_wa == 6'd17) seen17++;
    if (!rst) begin
      acc_out = out_ready && (sb.size() > 0);
      acc_in  = in_valid && (sb.size() < 2);
      if (flush) begin
        sb.delete();
      end else begin
        if (acc_out) void'(sb.pop_front());
        if (acc_in) begin
          b.ctrl = in_ctrl; b.dw = in_dw_alu; b.dr1 = in_dr1; b.dr2 = in_dr2; b.wa = in_wa;
          sb.push_back(b);
        end
      end
    end
  end

  initial begin
    all_ctrl = '0;
    all_ctrl[WE_BR] = 1'b1;
    all_ctrl[W_RAM] = 1'b1;
    all_ctrl[R_RAM] = 1'b1;
    rst = 1'b1; flush = 1'b0; out_ready = 1'b0;
    drive(1'b0, 3'd0, 64'd0, 6'd0);
    repeat (3) step();
    rst = 1'b0;
    step();

    // Streaming at full rate.
    out_ready = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      drive(1'b1, 3'd1, 64'(k), 6'(k));
      step();
    end
    drive(1'b0, 3'd0, 64'd0, 6'd0);
    repeat (3) step();

    // Downstream stall: A then B, B held off for three cycles.
    out_ready = 1'b0;
    drive(1'b1, 3'd2, 64'hA, 6'd10);
    step();
    drive(1'b1, 3'd4, 64'hB, 6'd11);
    step();
    drive(1'b0, 3'd0, 64'd0, 6'd0);
    repeat (2) step();
    out_ready = 1'b1;
    repeat (3) step();

    // Flush while full of all-ones control beats.
    out_ready = 1'b0;
    drive(1'b1, all_ctrl, 64'h11, 6'd1);
    step();
    drive(1'b1, all_ctrl, 64'h22, 6'd2);
    step();
    drive(1'b0, 3'd0, 64'd0, 6'd0);
    flush = 1'b1;
    step();
    flush = 1'b0;
    out_ready = 1'b1;
    repeat (3) step();

    // Flush coincident with an accepted beat.
    watch17 = 1'b1;
    drive(1'b1, 3'd1, 64'h17, 6'd17);
    flush = 1'b1;
    step();
    flush = 1'b0;
    drive(1'b0, 3'd0, 64'd0, 6'd0);
    repeat (4) step();
    watch17 = 1'b0;
    chk("wa17_never_presented", 64'(seen17), 64'd0);

    // Asynchronous reset between edges while full.
    out_ready = 1'b0;
    drive(1'b1, all_ctrl, 64'h33, 6'd3);
    step();
    drive(1'b1, all_ctrl, 64'h44, 6'd4);
    step();
    drive(1'b0, 3'd0, 64'd0, 6'd0);
    @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
    chk("rst_out_ctrl", {61'd0, out_ctrl}, 64'd0);
    chk("rst_out_dw_alu", out_dw_alu, 64'd0);
    chk("rst_out_wa", {58'd0, out_wa}, 64'd0);
    chk("rst_occ", {62'd0, occ}, 64'd0);
    chk("rst_in_ready", {63'd0, in_ready}, 64'd1);
    @(posedge clk);
    #1;
    rst = 1'b0;
    step();
    chk("post_rst_in_ready", {63'd0, in_ready}, 64'd1);
    chk("post_rst_occ", {62'd0, occ}, 64'd0);

    // Random traffic.
    for (int i = 0; i < 10000; i++) begin
      drive(1'($urandom_range(0, 1)), 3'($urandom), {$urandom, $urandom}, 6'($urandom));
      out_ready = 1'($urandom_range(0, 1));
      flush = ($urandom_range(0, 63) == 0);
      step();
    end
    drive(1'b0, 3'd0, 64'd0, 6'd0);
    flush = 1'b0;
    out_ready = 1'b1;
    repeat (4) step();

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
